usr_seq_ctrl: RTL and testbench

//  Sequencer for the N-bit universal shift register. Accepts a command (parallel word, direction,

---
 rtl/usr_seq_ctrl_pkg.sv | 21 ++
 rtl/usr_seq_ctrl_if.sv | 23 ++
 rtl/usr_bit_counter.sv | 31 +++
 rtl/usr_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_usr_seq_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/usr_seq_ctrl_pkg.sv
// Shared types and register mode encodings for the universal shift register sequencer.
package usr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    // Mode select for a shift in the latched direction (0 = right, 1 = left).
    function automatic logic [1:0] shift_mode(input logic dir);
        return dir ? USR_SHL : USR_SHR;
    endfunction

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Command channel (valid/ready plus payload) feeding the sequencer.
interface usr_seq_ctrl_if #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [N-1:0]  cmd_data;
    logic          cmd_dir;
    logic [CW-1:0] cmd_amt;
    logic          cmd_fill;
    logic          cmd_rot;

    modport master (
        output cmd_valid, cmd_data, cmd_dir, cmd_amt, cmd_fill, cmd_rot,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_dir, cmd_amt, cmd_fill, cmd_rot,
        output cmd_ready
    );
endinterface

// File: rtl/usr_bit_counter.sv
// Loadable down-counter: load value saturates to N, decrement stops at zero.
module usr_bit_counter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);
    localparam logic [CW-1:0] NMAX = CW'(N);

    logic [CW-1:0] cnt_q;

    // Counter register: load has priority over decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= (load_val_i > NMAX) ? NMAX : load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/usr_seq_ctrl.sv
// Sequencer for an N-bit universal shift register: LOAD, counted SHIFTs, DONE pulse.
// Optional feature macro: USR_ROTATE_EN (rotate by feeding the outgoing bit back as fill).
module usr_seq_ctrl
    import usr_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    usr_seq_ctrl_if.slave cmd,
    input  logic          pause,
    output logic [1:0]    usr_s,
    output logic [N-1:0]  usr_i,
    output logic          usr_msb_in,
    output logic          usr_lsb_in,
    input  logic [N-1:0]  usr_q,
    output logic          ser_out,
    output logic          ser_valid,
    output logic          busy,
    output logic          done
);
    state_t        state_q, state_d;
    logic [1:0]    usr_s_q, usr_s_d;
    logic [N-1:0]  usr_i_q, usr_i_d;
    logic          msb_q, msb_d, lsb_q, lsb_d;
    logic          ser_out_q, ser_out_d, ser_valid_q, ser_valid_d;
    logic          busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic          dir_q, dir_d, fill_q, fill_d;
    logic          cnt_load, cnt_en, cnt_zero, go_shift;
    logic [CW-1:0] cnt;
    logic          usr_q_unused;

    assign usr_q_unused = ^usr_q;

`ifdef USR_ROTATE_EN
    logic rot_q, rot_d;
`else
    logic rot_unused;
    assign rot_unused = cmd.cmd_rot;
`endif

    usr_bit_counter #(.N(N), .CW(CW)) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (cnt_load),
        .load_val_i (cmd.cmd_amt),
        .en_i       (cnt_en),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // State, latched command fields and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            usr_s_q     <= USR_HOLD;
            usr_i_q     <= '0;
            msb_q       <= 1'b0;
            lsb_q       <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            dir_q       <= 1'b0;
            fill_q      <= 1'b0;
`ifdef USR_ROTATE_EN
            rot_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            usr_s_q     <= usr_s_d;
            usr_i_q     <= usr_i_d;
            msb_q       <= msb_d;
            lsb_q       <= lsb_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            dir_q       <= dir_d;
            fill_q      <= fill_d;
`ifdef USR_ROTATE_EN
            rot_q       <= rot_d;
`endif
        end
    end

    // Next-state and next-output decode; outputs describe the cycle being entered.
    // ser_valid_q doubles as "the current SHIFT cycle actually shifts" (not paused).
    always_comb begin
        state_d     = state_q;
        usr_s_d     = USR_HOLD;
        usr_i_d     = usr_i_q;
        msb_d       = 1'b0;
        lsb_d       = 1'b0;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        ready_d     = 1'b0;
        dir_d       = dir_q;
        fill_d      = fill_q;
`ifdef USR_ROTATE_EN
        rot_d       = rot_q;
`endif
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        go_shift    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid && ready_q) begin
                    state_d  = LOAD;
                    usr_s_d  = USR_LOAD;
                    usr_i_d  = cmd.cmd_data;
                    dir_d    = cmd.cmd_dir;
                    fill_d   = cmd.cmd_fill;
`ifdef USR_ROTATE_EN
                    rot_d    = cmd.cmd_rot;
`endif
                    cnt_load = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            LOAD: begin
                busy_d = 1'b1;
                if (cnt_zero) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = SHIFT;
                    go_shift = 1'b1;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                cnt_en = ser_valid_q;
                if (ser_valid_q && (cnt == CW'(1))) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (!pause) begin
                    go_shift = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        if (go_shift) begin
            usr_s_d     = shift_mode(dir_q);
            ser_out_d   = dir_q ? usr_q[N-1] : usr_q[0];
            ser_valid_d = 1'b1;
            msb_d       = fill_q;
            lsb_d       = fill_q;
`ifdef USR_ROTATE_EN
            if (rot_q) begin
                if (dir_q) lsb_d = usr_q[N-1];
                else       msb_d = usr_q[0];
            end
`endif
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign usr_s         = usr_s_q;
    assign usr_i         = usr_i_q;
    assign usr_msb_in    = msb_q;
    assign usr_lsb_in    = lsb_q;
    assign ser_out       = ser_out_q;
    assign ser_valid     = ser_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Directed bench: sequencer driving a behavioural 4-bit universal shift register.
module tb_usr_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] usr_s;
    logic [3:0] usr_i;
    logic       usr_msb_in, usr_lsb_in;
    logic [3:0] usr_q = 4'h0;
    logic       ser_out, ser_valid, busy, done;

    int total = 0;
    int bad   = 0;

    usr_seq_ctrl_if #(.N(4)) cif ();

    usr_seq_ctrl #(.N(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd        (cif.slave),
        .pause      (pause),
        .usr_s      (usr_s),
        .usr_i      (usr_i),
        .usr_msb_in (usr_msb_in),
        .usr_lsb_in (usr_lsb_in),
        .usr_q      (usr_q),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Universal shift register, updating on the falling edge.
    always @(negedge clk) begin
        case (usr_s)
            2'b01:   usr_q <= {usr_msb_in, usr_q[3:1]};
            2'b10:   usr_q <= {usr_q[2:0], usr_lsb_in};
            2'b11:   usr_q <= usr_i;
            default: usr_q <= usr_q;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and run it to completion; k counts cycles after the handshake cycle.
    task automatic run_cmd(input string tag, input logic [3:0] data, input logic dir,
                           input logic [2:0] amt, input logic fill, input logic rot,
                           input int p_from, input int p_len, input logic [3:0] p_q,
                           output int lat, output logic [3:0] sbits,
                           output int nser, output int ndone);
        int k;
        cif.cmd_valid = 1'b1;
        cif.cmd_data  = data;
        cif.cmd_dir   = dir;
        cif.cmd_amt   = amt;
        cif.cmd_fill  = fill;
        cif.cmd_rot   = rot;
        tick();
        cif.cmd_valid = 1'b0;
        cif.cmd_data  = ~data;
        k = 1; lat = -1; nser = 0; ndone = 0; sbits = 4'h0;
        while (k < 40 && lat < 0) begin
            if (k == 1) begin
                chk({tag, "_load_s"}, 32'(usr_s), 32'(2'b11));
                chk({tag, "_load_i"}, 32'(usr_i), 32'(data));
                chk({tag, "_load_rdy"}, 32'(cif.cmd_ready), 32'(1'b0));
                chk({tag, "_load_busy"}, 32'(busy), 32'(1'b1));
            end
            if (p_len > 0 && k == p_from + p_len) begin
                chk({tag, "_pause_q"}, 32'(usr_q), 32'(p_q));
                chk({tag, "_pause_vld"}, 32'(ser_valid), 32'(1'b0));
                chk({tag, "_pause_s"}, 32'(usr_s), 32'(2'b00));
            end
            if (ser_valid) begin
                if (nser < 4) sbits[nser] = ser_out;
                nser++;
            end
            if (done) begin
                ndone++;
                lat = k;
            end
            if (lat < 0) begin
                pause = (k >= p_from) && (k < p_from + p_len);
                tick();
                k++;
            end
        end
        pause = 1'b0;
        tick();
        if (done) ndone++;
        chk({tag, "_idle_rdy"}, 32'(cif.cmd_ready), 32'(1'b1));
        chk({tag, "_idle_busy"}, 32'(busy), 32'(1'b0));
    endtask

    initial begin
        int lat, nser, ndone;
        logic [3:0] sb;
        cif.cmd_valid = 1'b0;
        cif.cmd_data  = 4'h0;
        cif.cmd_dir   = 1'b0;
        cif.cmd_amt   = 3'd0;
        cif.cmd_fill  = 1'b0;
        cif.cmd_rot   = 1'b0;
        #12;
        chk("rst_s", 32'(usr_s), 32'(2'b00));
        chk("rst_rdy", 32'(cif.cmd_ready), 32'(1'b1));
        reset_n = 1'b1;
        tick();

        // 1. Reset in the middle of a SHIFT phase.
        cif.cmd_valid = 1'b1; cif.cmd_data = 4'b1011; cif.cmd_dir = 1'b0;
        cif.cmd_amt = 3'd4; cif.cmd_fill = 1'b0;
        tick();
        cif.cmd_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_shift", 32'(usr_s), 32'(2'b01));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_s", 32'(usr_s), 32'(2'b00));
        chk("mid_rst_outs", 32'({usr_i, usr_msb_in, usr_lsb_in, ser_out, ser_valid, busy, done}), 32'h0);
        chk("mid_rst_rdy", 32'(cif.cmd_ready), 32'(1'b1));
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'(1'b0));

        // 2. Right shift by 2, fill 0.
        run_cmd("t2", 4'b1011, 1'b0, 3'd2, 1'b0, 1'b0, 0, 0, 4'h0, lat, sb, nser, ndone);
        chk("t2_lat", 32'(lat), 32'd4);
        chk("t2_nser", 32'(nser), 32'd2);
        chk("t2_ser", 32'(sb[1:0]), 32'(2'b11));
        chk("t2_q", 32'(usr_q), 32'(4'b0010));
        chk("t2_ndone", 32'(ndone), 32'd1);

        // 3. Left shift by 4, fill 1.
        run_cmd("t3", 4'b1011, 1'b1, 3'd4, 1'b1, 1'b0, 0, 0, 4'h0, lat, sb, nser, ndone);
        chk("t3_lat", 32'(lat), 32'd6);
        chk("t3_nser", 32'(nser), 32'd4);
        chk("t3_ser", 32'(sb), 32'(4'b1101));
        chk("t3_q", 32'(usr_q), 32'(4'b1111));
        chk("t3_ndone", 32'(ndone), 32'd1);

        // 4. Zero-length command: load only.
        run_cmd("t4", 4'hA, 1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 4'h0, lat, sb, nser, ndone);
        chk("t4_lat", 32'(lat), 32'd2);
        chk("t4_nser", 32'(nser), 32'd0);
        chk("t4_q", 32'(usr_q), 32'(4'hA));

        // 5. Saturating count (7 -> 4) with pause for three cycles mid-shift.
        run_cmd("t5", 4'b0110, 1'b0, 3'd7, 1'b1, 1'b0, 3, 3, 4'b1101, lat, sb, nser, ndone);
        chk("t5_lat", 32'(lat), 32'd9);
        chk("t5_nser", 32'(nser), 32'd4);
        chk("t5_ser", 32'(sb), 32'(4'b0110));
        chk("t5_q", 32'(usr_q), 32'(4'b1111));
        chk("t5_ndone", 32'(ndone), 32'd1);

        // 6. Rotate request, right by 1.
        run_cmd("t6", 4'b1001, 1'b0, 3'd1, 1'b0, 1'b1, 0, 0, 4'h0, lat, sb, nser, ndone);
        chk("t6_lat", 32'(lat), 32'd3);
`ifdef USR_ROTATE_EN
        chk("t6_q", 32'(usr_q), 32'(4'b1100));
`else
        chk("t6_q", 32'(usr_q), 32'(4'b0100));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
